// File: rtl/alu_result_display_if.sv
// Handshake and result bus between the 4-bit ALU and its display stage.
interface alu_result_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;

  modport master (
    output in_valid, op, result, carry, overflow, zero,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, result, carry, overflow, zero,
    output in_ready
  );
endinterface

// File: rtl/alu_result_display.sv
// Captures one ALU result per handshake and drives two active-low seven-segment digits
// plus flag LEDs. Optional overflow blinking is enabled by defining OVF_BLINK_EN.
module alu_result_display #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned BLINK_W     = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_result_display_if.slave  in_if,
  output logic [7:0]           seg0_o,
  output logic [7:0]           seg1_o,
  output logic [2:0]           flags_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              ready_q;
  logic [2:0]        op_q;
  logic [3:0]        result_q;
  logic [2:0]        flags_st_q;
  logic [7:0]        seg0_q;
  logic [7:0]        seg1_q;
  logic [2:0]        flags_q;

  logic [7:0]        seg0_d;
  logic [7:0]        seg1_d;
  logic [2:0]        flags_d;
  logic [3:0]        mag_s;
  logic              accept_s;
  logic              blank_s;

  if (BLINK_W < 1) begin : g_blink_w_invalid
  end

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'h03;
      4'h1:    g = 8'h9F;
      4'h2:    g = 8'h25;
      4'h3:    g = 8'h0D;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h49;
      4'h6:    g = 8'h41;
      4'h7:    g = 8'h1F;
      4'h8:    g = 8'h01;
      4'h9:    g = 8'h09;
      4'hA:    g = 8'h11;
      4'hB:    g = 8'hC1;
      4'hC:    g = 8'h63;
      4'hD:    g = 8'h85;
      4'hE:    g = 8'h61;
      4'hF:    g = 8'h71;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  assign accept_s       = in_if.in_valid & ready_q;
  assign in_if.in_ready = ready_q;

  // Handshake FSM, hold timer and capture of the accepted result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hold_q     <= {HOLD_W{1'b0}};
      ready_q    <= 1'b1;
      op_q       <= 3'b000;
      result_q   <= 4'b0000;
      flags_st_q <= 3'b000;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHOW: begin
          if (accept_s) begin
            state_q <= ST_HOLD;
            ready_q <= 1'b0;
            hold_q  <= {HOLD_W{1'b0}};
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_SHOW;
            ready_q <= 1'b1;
            hold_q  <= {HOLD_W{1'b0}};
          end else begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          hold_q  <= {HOLD_W{1'b0}};
        end
      endcase
      if (accept_s) begin
        op_q       <= in_if.op;
        result_q   <= in_if.result;
        flags_st_q <= {in_if.carry, in_if.overflow, in_if.zero};
      end
    end
  end

`ifdef OVF_BLINK_EN
  logic [BLINK_W-1:0] blink_q;

  // Free-running blink timer, restarted on each accept so digits start lit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_q <= {BLINK_W{1'b0}};
    end else if (accept_s) begin
      blink_q <= {BLINK_W{1'b0}};
    end else begin
      blink_q <= blink_q + BLINK_W'(1);
    end
  end

  assign blank_s = (op_q[2:1] == 2'b00) & flags_st_q[1] & blink_q[BLINK_W-1];
`else
  assign blank_s = 1'b0;
`endif

  // Glyph selection from the stored result.
  always_comb begin
    seg1_d  = SEG_BLANK;
    seg0_d  = SEG_BLANK;
    flags_d = flags_st_q;
    mag_s   = result_q;
    if (result_q[3]) begin
      mag_s = 4'b0000 - result_q;
    end else begin
      mag_s = result_q;
    end
    case (op_q)
      3'b000, 3'b001: begin
        seg1_d = result_q[3] ? SEG_DASH : SEG_BLANK;
        seg0_d = glyph(mag_s);
      end
      3'b010, 3'b011, 3'b100, 3'b101: begin
        seg0_d = glyph(result_q);
      end
      3'b110, 3'b111: begin
        seg0_d = glyph({3'b000, result_q[0]});
      end
      default: begin
        seg0_d = SEG_BLANK;
      end
    endcase
    if (blank_s) begin
      seg1_d = SEG_BLANK;
      seg0_d = SEG_BLANK;
    end else begin
      seg1_d = seg1_d;
      seg0_d = seg0_d;
    end
  end

  // Output registers; the dashes stay up until the first result has been captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg0_q  <= SEG_DASH;
      seg1_q  <= SEG_DASH;
      flags_q <= 3'b000;
    end else if (state_q != ST_IDLE) begin
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      flags_q <= flags_d;
    end else begin
      seg0_q  <= seg0_q;
      seg1_q  <= seg1_q;
      flags_q <= flags_q;
    end
  end

  assign seg0_o  = seg0_q;
  assign seg1_o  = seg1_q;
  assign flags_o = flags_q;

endmodule
